change_dispenser: RTL and testbench

- Pays out change computed by the coffee machine, coin by coin, through a two-chute coin ejector (500 and 100 chutes).
- It is the outbound counterpart of the coin counter: that block accumulates coin pulses in; this block emits coin pulses out.
- Amounts are in 100-units, the same units the coin counter and change subtractor use.
- Uses the largest coin first, tracks chute stock, waits for a per-coin drop confirmation, and flags a fault when it cannot pay.

---
 rtl/change_dispenser.sv | 159 +++++++++++++++
 tb/tb_change_dispenser.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/change_dispenser.sv
// Coin-by-coin change payout through a two-chute ejector (500 and 100 chutes).
// Largest coin first, per-coin drop confirmation, sticky fault when payment cannot complete.
module change_dispenser #(
  parameter int PULSE_CYCLES   = 4,
  parameter int GAP_CYCLES     = 4,
  parameter int ACK_TIMEOUT    = 16,
  parameter int STOCK_500_INIT = 3,
  parameter int STOCK_100_INIT = 10
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [3:0] amount,
  input  logic       eject_ack,
  output logic       eject_500,
  output logic       eject_100,
  output logic       busy,
  output logic       done,
  output logic       fault,
  output logic [3:0] remaining,
  output logic [3:0] stock_500,
  output logic [4:0] stock_100
);

  localparam int TMR_MAX = (PULSE_CYCLES > GAP_CYCLES)
                         ? ((PULSE_CYCLES > ACK_TIMEOUT) ? PULSE_CYCLES : ACK_TIMEOUT)
                         : ((GAP_CYCLES > ACK_TIMEOUT) ? GAP_CYCLES : ACK_TIMEOUT);
  localparam int TMR_W = $clog2(TMR_MAX + 1);

  localparam logic [TMR_W-1:0] PULSE_LAST = TMR_W'(PULSE_CYCLES - 1);
  localparam logic [TMR_W-1:0] GAP_LAST   = TMR_W'(GAP_CYCLES - 1);
  localparam logic [TMR_W-1:0] ACK_LAST   = TMR_W'(ACK_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CHOOSE, S_PULSE500, S_PULSE100, S_WAIT_ACK, S_GAP, S_FINISH, S_FAULT
  } state_t;

  state_t           r_state;
  logic [TMR_W-1:0] r_timer;
  logic             r_ack_seen;
  logic             r_is500;
  logic             r_ej500;
  logic             r_ej100;
  logic             r_busy;
  logic             r_done;
  logic             r_fault;
  logic [3:0]       r_remaining;
  logic [3:0]       r_stock_500;
  logic [4:0]       r_stock_100;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_timer     <= '0;
      r_ack_seen  <= 1'b0;
      r_is500     <= 1'b0;
      r_ej500     <= 1'b0;
      r_ej100     <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_fault     <= 1'b0;
      r_remaining <= '0;
      r_stock_500 <= 4'(STOCK_500_INIT);
      r_stock_100 <= 5'(STOCK_100_INIT);
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            if (amount != 4'd0) begin
              r_remaining <= amount;
              r_busy      <= 1'b1;
              r_state     <= S_CHOOSE;
            end else begin
              r_done <= 1'b1;
            end
          end
        end
        S_CHOOSE: begin
          r_timer <= '0;
          if (r_remaining == 4'd0) begin
            r_done  <= 1'b1;
            r_state <= S_FINISH;
          end else if (r_remaining >= 4'd5 && r_stock_500 != 4'd0) begin
            r_is500 <= 1'b1;
            r_ej500 <= 1'b1;
            r_state <= S_PULSE500;
          end else if (r_stock_100 != 5'd0) begin
            r_is500 <= 1'b0;
            r_ej100 <= 1'b1;
            r_state <= S_PULSE100;
          end else begin
            r_fault <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_FAULT;
          end
        end
        S_PULSE500, S_PULSE100: begin
          if (eject_ack) r_ack_seen <= 1'b1;
          if (r_timer == PULSE_LAST) begin
            r_timer <= '0;
            r_ej500 <= 1'b0;
            r_ej100 <= 1'b0;
            r_state <= S_WAIT_ACK;
          end else begin
            r_timer <= r_timer + TMR_W'(1);
          end
        end
        // An ack seen during the pulse, or arriving now, confirms the coin immediately.
        S_WAIT_ACK: begin
          if (r_ack_seen || eject_ack) begin
            r_ack_seen <= 1'b0;
            r_timer    <= '0;
            r_state    <= S_GAP;
            if (r_is500) begin
              r_remaining <= r_remaining - 4'd5;
              r_stock_500 <= r_stock_500 - 4'd1;
            end else begin
              r_remaining <= r_remaining - 4'd1;
              r_stock_100 <= r_stock_100 - 5'd1;
            end
          end else if (r_timer == ACK_LAST) begin
            r_fault <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_FAULT;
          end else begin
            r_timer <= r_timer + TMR_W'(1);
          end
        end
        S_GAP: begin
          if (r_timer == GAP_LAST) begin
            r_timer <= '0;
            r_state <= S_CHOOSE;
          end else begin
            r_timer <= r_timer + TMR_W'(1);
          end
        end
        S_FINISH: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        S_FAULT: begin
          r_state <= S_FAULT;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign eject_500 = r_ej500;
  assign eject_100 = r_ej100;
  assign busy      = r_busy;
  assign done      = r_done;
  assign fault     = r_fault;
  assign remaining = r_remaining;
  assign stock_500 = r_stock_500;
  assign stock_100 = r_stock_100;

endmodule

// File: tb/tb_change_dispenser.sv
// Bench for change_dispenser: table vectors, hand-written corner sequences and a
// randomized run against a greedy-payout reference model.
module tb_change_dispenser;
  localparam int PULSE = 4;
  localparam int ACKTO = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       start;
  logic [3:0] amount;
  logic       ack;
  int         sel;

  logic       st[3];
  logic       ak[3];
  logic       e5[3];
  logic       e1[3];
  logic       by[3];
  logic       dn[3];
  logic       ft[3];
  logic [3:0] rm[3];
  logic [3:0] s5[3];
  logic [4:0] s1[3];

  assign st[0] = start && (sel == 0);
  assign st[1] = start && (sel == 1);
  assign st[2] = start && (sel == 2);
  assign ak[0] = ack && (sel == 0);
  assign ak[1] = ack && (sel == 1);
  assign ak[2] = ack && (sel == 2);

  change_dispenser u_a (
    .clock(clk), .reset(rst), .start(st[0]), .amount(amount), .eject_ack(ak[0]),
    .eject_500(e5[0]), .eject_100(e1[0]), .busy(by[0]), .done(dn[0]), .fault(ft[0]),
    .remaining(rm[0]), .stock_500(s5[0]), .stock_100(s1[0]));

  change_dispenser #(.STOCK_500_INIT(0)) u_b (
    .clock(clk), .reset(rst), .start(st[1]), .amount(amount), .eject_ack(ak[1]),
    .eject_500(e5[1]), .eject_100(e1[1]), .busy(by[1]), .done(dn[1]), .fault(ft[1]),
    .remaining(rm[1]), .stock_500(s5[1]), .stock_100(s1[1]));

  change_dispenser #(.STOCK_500_INIT(0), .STOCK_100_INIT(2)) u_c (
    .clock(clk), .reset(rst), .start(st[2]), .amount(amount), .eject_ack(ak[2]),
    .eject_500(e5[2]), .eject_100(e1[2]), .busy(by[2]), .done(dn[2]), .fault(ft[2]),
    .remaining(rm[2]), .stock_500(s5[2]), .stock_100(s1[2]));

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Results of the most recent payout
  int res_n5, res_n1, res_done, res_done_cyc, res_fault, res_first, res_lat, res_busy_hi;

  task do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task chk_reset_state(input string tag, input int exp5, input int exp1);
    chk({tag, "_remaining"}, int'(rm[sel]), 0);
    chk({tag, "_busy"}, int'(by[sel]), 0);
    chk({tag, "_done"}, int'(dn[sel]), 0);
    chk({tag, "_fault"}, int'(ft[sel]), 0);
    chk({tag, "_ejects"}, int'(e5[sel]) + int'(e1[sel]), 0);
    chk({tag, "_stock500"}, int'(s5[sel]), exp5);
    chk({tag, "_stock100"}, int'(s1[sel]), exp1);
  endtask

  // mode 0: ack one cycle after eject falls; 1: ack at random point in pulse/wait; 2: never ack
  task do_pay(input int amt, input int mode, input int repulse_at);
    int cyc, prev_any, any, width, ack_at, wait_start, both, fin;
    res_n5 = 0; res_n1 = 0; res_done = 0; res_done_cyc = -1; res_fault = 0;
    res_first = -1; res_lat = -1; res_busy_hi = 0;
    cyc = 0; prev_any = 0; width = 0; ack_at = -1; wait_start = 0; both = 0; fin = 0;
    amount = 4'(amt);
    start = 1'b1;
    ack = 1'b0;
    while (!fin && cyc < 2000) begin
      @(posedge clk); #1;
      cyc++;
      start = (cyc == repulse_at);
      amount = start ? 4'd9 : 4'($urandom);
      any = int'(e5[sel] | e1[sel]);
      if (e5[sel] && e1[sel]) both++;
      if (by[sel]) res_busy_hi++;
      if (any != 0 && prev_any == 0) begin
        if (e5[sel]) res_n5++; else res_n1++;
        width = 1;
        if (res_first < 0) res_first = cyc;
        if (mode == 1) ack_at = cyc + $urandom_range(0, 10);
      end else if (any != 0) begin
        width++;
      end else if (prev_any != 0) begin
        chk("pulse_width", width, PULSE);
        wait_start = cyc;
        if (mode == 0) ack_at = cyc + 1;
      end
      if (dn[sel]) begin
        res_done++;
        if (res_done_cyc < 0) res_done_cyc = cyc;
      end else if (res_done > 0) begin
        fin = 1;
      end
      if (ft[sel]) begin
        res_fault = 1;
        res_lat = cyc - wait_start;
        fin = 1;
      end
      prev_any = any;
      ack = (mode != 2) && (cyc == ack_at);
    end
    start = 1'b0;
    ack = 1'b0;
    chk("payout_budget", fin, 1);
    chk("eject_overlap", both, 0);
    chk("busy_at_end", int'(by[sel]), 0);
  endtask

  typedef struct {
    int amt; int n5; int n1; int rem; int s5; int s1; int flt;
  } vec_t;
  vec_t tbl[4];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int rises, pe, qsum, a, mode, n5, n1, r, rem, m5, m1;
    rst = 1'b1; start = 1'b0; amount = 4'd0; ack = 1'b0; sel = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk_reset_state("rst_a", 3, 10);
    sel = 1; chk("rst_b_stock500", int'(s5[1]), 0);
    sel = 2; chk("rst_c_stock100", int'(s1[2]), 2);
    sel = 0;

    // Cumulative sequence on the default unit: stocks carry between rows
    tbl[0] = '{amt: 7,  n5: 1, n1: 2, rem: 0, s5: 2, s1: 8, flt: 0};
    tbl[1] = '{amt: 0,  n5: 0, n1: 0, rem: 0, s5: 2, s1: 8, flt: 0};
    tbl[2] = '{amt: 15, n5: 2, n1: 5, rem: 0, s5: 0, s1: 3, flt: 0};
    tbl[3] = '{amt: 4,  n5: 0, n1: 3, rem: 1, s5: 0, s1: 0, flt: 1};
    for (int i = 0; i < 4; i++) begin
      do_pay(tbl[i].amt, 0, -1);
      chk($sformatf("tbl%0d_n500", i), res_n5, tbl[i].n5);
      chk($sformatf("tbl%0d_n100", i), res_n1, tbl[i].n1);
      chk($sformatf("tbl%0d_remaining", i), int'(rm[0]), tbl[i].rem);
      chk($sformatf("tbl%0d_stock500", i), int'(s5[0]), tbl[i].s5);
      chk($sformatf("tbl%0d_stock100", i), int'(s1[0]), tbl[i].s1);
      chk($sformatf("tbl%0d_fault", i), res_fault, tbl[i].flt);
      chk($sformatf("tbl%0d_done_count", i), res_done, 1 - tbl[i].flt);
      if (tbl[i].amt == 0) begin
        chk("zero_done_cycle", res_done_cyc, 1);
        chk("zero_busy_cycles", res_busy_hi, 0);
      end else begin
        chk($sformatf("tbl%0d_first_eject_cycle", i), res_first, 2);
      end
    end

    // Fault is sticky and start is ignored while faulted
    amount = 4'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("fault_sticky", int'(ft[0]), 1);
    chk("fault_rem_frozen", int'(rm[0]), 1);
    chk("fault_busy", int'(by[0]), 0);
    chk("fault_ejects", int'(e5[0]) + int'(e1[0]), 0);
    do_reset();
    chk_reset_state("rst_after_fault", 3, 10);

    // Withheld ack: fault ACKTO cycles after entering WAIT_ACK
    do_pay(1, 2, -1);
    chk("timeout_n100", res_n1, 1);
    chk("timeout_fault", res_fault, 1);
    chk("timeout_latency", res_lat, ACKTO);
    chk("timeout_remaining", int'(rm[0]), 1);
    chk("timeout_stock100", int'(s1[0]), 10);
    chk("timeout_done", res_done, 0);
    do_reset();

    // Start re-pulsed with a new amount during a payout is ignored
    do_pay(2, 0, 3);
    chk("repulse_n100", res_n1, 2);
    chk("repulse_n500", res_n5, 0);
    chk("repulse_remaining", int'(rm[0]), 0);
    chk("repulse_done", res_done, 1);
    chk("repulse_stock100", int'(s1[0]), 8);
    do_reset();

    // Reset during the second coin's pulse
    amount = 4'd2; start = 1'b1;
    rises = 0; pe = 0;
    for (int k = 0; k < 100 && rises < 2; k++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (e1[0] && pe == 0) rises++;
      ack = (pe != 0) && !e1[0];
      pe = int'(e1[0]);
    end
    ack = 1'b0;
    chk("midpulse_reached", rises, 2);
    chk("midpulse_stock100", int'(s1[0]), 9);
    do_reset();
    chk_reset_state("midpulse_rst", 3, 10);
    qsum = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      qsum += int'(dn[0]) + int'(e1[0]) + int'(e5[0]) + int'(by[0]);
    end
    chk("midpulse_quiet", qsum, 0);

    // No 500 stock: six 100 coins
    sel = 1;
    do_pay(6, 0, -1);
    chk("b_n500", res_n5, 0);
    chk("b_n100", res_n1, 6);
    chk("b_stock100", int'(s1[1]), 4);
    chk("b_remaining", int'(rm[1]), 0);
    chk("b_done", res_done, 1);

    // Two 100 coins only: pays two, then faults
    sel = 2;
    do_pay(3, 0, -1);
    chk("c_n100", res_n1, 2);
    chk("c_fault", res_fault, 1);
    chk("c_remaining", int'(rm[2]), 1);
    chk("c_stock100", int'(s1[2]), 0);
    chk("c_busy", int'(by[2]), 0);
    chk("c_done", res_done, 0);

    // Randomized payouts against a greedy model with stock tracking
    sel = 0;
    do_reset();
    m5 = 3; m1 = 10;
    for (int t = 0; t < 25; t++) begin
      a = $urandom_range(0, 15);
      mode = $urandom_range(0, 1);
      n5 = (a / 5 < m5) ? a / 5 : m5;
      r = a - 5 * n5;
      n1 = (r < m1) ? r : m1;
      rem = r - n1;
      m5 -= n5;
      m1 -= n1;
      do_pay(a, mode, -1);
      chk($sformatf("rnd%0d_n500", t), res_n5, n5);
      chk($sformatf("rnd%0d_n100", t), res_n1, n1);
      chk($sformatf("rnd%0d_remaining", t), int'(rm[0]), rem);
      chk($sformatf("rnd%0d_stock500", t), int'(s5[0]), m5);
      chk($sformatf("rnd%0d_stock100", t), int'(s1[0]), m1);
      chk($sformatf("rnd%0d_fault", t), res_fault, int'(rem != 0));
      chk($sformatf("rnd%0d_done", t), res_done, int'(rem == 0));
      if (n5 + n1 > 0) chk($sformatf("rnd%0d_first_eject", t), res_first, 2);
      if (rem != 0) begin
        do_reset();
        chk_reset_state($sformatf("rnd%0d_rst", t), 3, 10);
        m5 = 3; m1 = 10;
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
